multicycle_controlunit: RTL and testbench



---
 rtl/multicycle_controlunit.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controlunit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controlunit.sv
// Multicycle RV32I control unit: Moore FSM that walks each instruction through
// fetch/decode/execute/memory/writeback on a shared memory port and single ALU,
// owns the instruction register and flags unsupported encodings.
module multicycle_controlunit #(
  parameter int ALUCTRL_W   = 3,
  parameter int IMMSRC_W    = 3,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  input  logic                 EQ,
  output logic [31:0]          instr,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic                 AdrSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd15
  } state_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b011);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b101);

  localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(3'b000);
  localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(3'b001);
  localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(3'b010);
  localparam logic [IMMSRC_W-1:0] IMM_J = IMMSRC_W'(3'b011);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] ir_q;
  logic        rdy;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [ALUCTRL_W-1:0] alu_sel;
  logic        alu_ok;

  // With waiting disabled the memory is treated as always ready.
  assign rdy    = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign f7b5   = ir_q[30];
  assign instr  = ir_q;
  assign state  = state_q;

  // State register and instruction register; IR loads only on a completed fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= IR_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && rdy) begin
        ir_q <= mem_rdata;
      end
    end
  end

  // ALU operation for R/I execute; funct7[5] selects sub only for R-type add.
  always_comb begin
    alu_sel = ALU_ADD;
    alu_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_sel = (state_q == EXECR && f7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_sel = ALU_AND;
      3'b110:  alu_sel = ALU_OR;
      3'b010:  alu_sel = ALU_SLT;
      default: alu_ok  = 1'b0;
    endcase
  end

  // Next-state and Moore outputs; write enables are suppressed while in reset.
  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = rdy;
        PCWrite = rdy;
        ALUSrcB = 2'b10;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_B;
        if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b010)
          state_d = MEMADR;
        else if (opcode == OP_RTYPE)
          state_d = EXECR;
        else if (opcode == OP_ITYPE)
          state_d = EXECI;
        else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00)
          state_d = BRANCH;
        else if (opcode == OP_JAL)
          state_d = JAL;
        else
          state_d = TRAP;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (rdy) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (rdy) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUctrl = alu_sel;
        state_d = alu_ok ? ALUWB : TRAP;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_I;
        ALUctrl = alu_sel;
        state_d = alu_ok ? ALUWB : TRAP;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUctrl = ALU_SUB;
        PCWrite = funct3[0] ? ~EQ : EQ;
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = IMM_J;
        PCWrite   = 1'b1;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = TRAP;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Scoreboard bench for multicycle_controlunit: stimulus pushes the hand-derived
// expected outputs of each cycle; a monitor pops and compares at the falling edge.
module tb_multicycle_controlunit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        EQ = 1'b0;
  logic [31:0] instr;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ALUctrl, ImmSrc;
  logic        illegal;
  logic [3:0]  state;

  localparam int X = -1;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [4:0]  en;   // {PCWrite, IRWrite, RegWrite, MemWrite, MemRead}
    logic        ill;
    int          adr;
    int          res;
    int          alu;
    int          imm;
    longint      ir;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_controlunit #(.ALUCTRL_W(3), .IMMSRC_W(3), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .EQ(EQ),
    .instr(instr), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string f, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0h expected=%0h", tag, f, got, exp);
    end
  endtask

  // Apply one cycle of inputs, record what the outputs must be, advance a cycle.
  task automatic cyc(input string tag, input logic [31:0] rd, input logic rdy, input logic eq,
                     input logic [3:0] st, input logic [4:0] en, input logic ill,
                     input int adr, input int res, input int alu, input int imm,
                     input longint ir);
    exp_t e;
    mem_rdata = rd;
    mem_ready = rdy;
    EQ        = eq;
    e.tag = tag; e.st = st; e.en = en; e.ill = ill;
    e.adr = adr; e.res = res; e.alu = alu; e.imm = imm; e.ir = ir;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "state", longint'(state), longint'(e.st));
        chk(e.tag, "enables", longint'({PCWrite, IRWrite, RegWrite, MemWrite, MemRead}),
            longint'(e.en));
        chk(e.tag, "illegal", longint'(illegal), longint'(e.ill));
        if (e.adr >= 0) chk(e.tag, "AdrSrc", longint'(AdrSrc), longint'(e.adr));
        if (e.res >= 0) chk(e.tag, "ResultSrc", longint'(ResultSrc), longint'(e.res));
        if (e.alu >= 0) chk(e.tag, "ALUctrl", longint'(ALUctrl), longint'(e.alu));
        if (e.imm >= 0) chk(e.tag, "ImmSrc", longint'(ImmSrc), longint'(e.imm));
        if (e.ir >= 0)  chk(e.tag, "instr", longint'(instr), e.ir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          drain;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // second reset cycle: state already FETCH, only MemRead may be high
    cyc("rst", 32'h0, 1, 0, 4'd0, 5'b00001, 0, 0, X, X, X, 32'h13);
    rst = 1'b0;

    rd = 32'h00500093; // addi x1,x0,5
    cyc("addi_f",  rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("addi_d",  rd, 1, 0, 4'd1, 5'b00000, 0, X, X, 0, 2, 32'h00500093);
    cyc("addi_x",  rd, 1, 0, 4'd7, 5'b00000, 0, X, X, 0, 0, X);
    cyc("addi_wb", rd, 1, 0, 4'd8, 5'b00100, 0, X, 0, X, X, X);

    rd = 32'h0000A103; // lw x2,0(x1), two wait cycles in MEMREAD
    cyc("lw_f",   rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("lw_d",   rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, 32'h0000A103);
    cyc("lw_a",   rd, 1, 0, 4'd2, 5'b00000, 0, X, X, 0, 0, X);
    cyc("lw_r0",  rd, 0, 0, 4'd3, 5'b00001, 0, 1, X, X, X, X);
    cyc("lw_r1",  rd, 0, 0, 4'd3, 5'b00001, 0, 1, X, X, X, X);
    cyc("lw_r2",  rd, 1, 0, 4'd3, 5'b00001, 0, 1, X, X, X, X);
    cyc("lw_wb",  rd, 1, 0, 4'd4, 5'b00100, 0, X, 1, X, X, 32'h0000A103);

    rd = 32'h0020A223; // sw x2,4(x1), fetch stall and write stall
    cyc("sw_fs",  rd, 0, 0, 4'd0, 5'b00001, 0, 0, X, X, X, 32'h0000A103);
    cyc("sw_f",   rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("sw_d",   rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, 32'h0020A223);
    cyc("sw_a",   rd, 1, 0, 4'd2, 5'b00000, 0, X, X, 0, 1, X);
    cyc("sw_w0",  rd, 0, 0, 4'd5, 5'b00010, 0, 1, X, X, X, X);
    cyc("sw_w1",  rd, 1, 0, 4'd5, 5'b00010, 0, 1, X, X, X, X);

    rd = 32'h00000463; // beq taken then not taken
    cyc("beq1_f", rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("beq1_d", rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, 32'h00000463);
    cyc("beq1_b", rd, 1, 1, 4'd9, 5'b10000, 0, X, 0, 1, X, X);
    cyc("beq0_f", rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("beq0_d", rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, X);
    cyc("beq0_b", rd, 1, 0, 4'd9, 5'b00000, 0, X, X, 1, X, X);

    rd = 32'h00001463; // bne: inverse sense
    cyc("bne1_f", rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("bne1_d", rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, 32'h00001463);
    cyc("bne1_b", rd, 1, 1, 4'd9, 5'b00000, 0, X, X, 1, X, X);
    cyc("bne0_f", rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("bne0_d", rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, X);
    cyc("bne0_b", rd, 1, 0, 4'd9, 5'b10000, 0, X, 0, 1, X, X);

    rd = 32'h40208033; // sub x0,x1,x2
    cyc("sub_f",  rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("sub_d",  rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, 32'h40208033);
    cyc("sub_x",  rd, 1, 0, 4'd6, 5'b00000, 0, X, X, 1, X, X);
    cyc("sub_wb", rd, 1, 0, 4'd8, 5'b00100, 0, X, 0, X, X, X);

    rd = 32'h0020E033; // or x0,x1,x2
    cyc("or_f",   rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("or_d",   rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, X);
    cyc("or_x",   rd, 1, 0, 4'd6, 5'b00000, 0, X, X, 3, X, X);
    cyc("or_wb",  rd, 1, 0, 4'd8, 5'b00100, 0, X, 0, X, X, X);

    rd = 32'h010000EF; // jal x1,16
    cyc("jal_f",  rd, 1, 0, 4'd0,  5'b11001, 0, 0, X, X, X, X);
    cyc("jal_d",  rd, 1, 0, 4'd1,  5'b00000, 0, X, X, X, X, 32'h010000EF);
    cyc("jal_j",  rd, 1, 0, 4'd10, 5'b10100, 0, X, 3, 0, 3, X);

    rd = 32'h0020A223; // sw aborted by reset during write stall
    cyc("swab_f", rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, X);
    cyc("swab_d", rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, X);
    cyc("swab_a", rd, 1, 0, 4'd2, 5'b00000, 0, X, X, X, 1, X);
    cyc("swab_w", rd, 0, 0, 4'd5, 5'b00010, 0, 1, X, X, X, X);
    rst = 1'b1;
    cyc("swab_r", rd, 0, 0, 4'd5, 5'b00000, 0, X, X, X, X, X);
    rst = 1'b0;

    rd = 32'h00101093; // slli-type funct3 001 unsupported -> TRAP from EXECI
    cyc("sll_f",  rd, 1, 0, 4'd0,  5'b11001, 0, 0, X, X, X, 32'h13);
    cyc("sll_d",  rd, 1, 0, 4'd1,  5'b00000, 0, X, X, X, X, 32'h00101093);
    cyc("sll_x",  rd, 1, 0, 4'd7,  5'b00000, 0, X, X, X, X, X);
    cyc("sll_t",  rd, 1, 0, 4'd15, 5'b00000, 1, X, X, X, X, X);
    rst = 1'b1;
    cyc("sll_r",  rd, 1, 0, 4'd15, 5'b00000, 1, X, X, X, X, X);
    rst = 1'b0;

    rd = 32'hFFFFFFFF; // unknown opcode, TRAP is terminal
    cyc("ill_f",  rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, 32'h13);
    cyc("ill_d",  rd, 1, 0, 4'd1, 5'b00000, 0, X, X, X, X, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++)
      cyc("ill_t", rd, 1, 1, 4'd15, 5'b00000, 1, X, X, X, X, 32'hFFFFFFFF);
    rst = 1'b1;
    cyc("ill_r",  rd, 1, 0, 4'd15, 5'b00000, 1, X, X, X, X, X);
    rst = 1'b0;
    cyc("ill_af", rd, 1, 0, 4'd0, 5'b11001, 0, 0, X, X, X, 32'h13);

    drain = 0;
    while (q.size() > 0 && drain < 5) begin
      @(posedge clk);
      drain++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
